answer_judge: RTL and testbench
===============================

Name: answer_judge

Overview:
- Player-side counterpart of the question path; consumes the displayed question and produces the score triggers.
- Steps the question index `bcd_state` (0..9) and accepts a buzz-in plus a 4-bit answer from each of two players.
- Compares the buzzed answer against `bcd_ans` and emits one-cycle score triggers that feed the per-player LED score counters.
- Also drives a beep on wrong answers and timeouts, and flags game over and the winner.

Parameters:
- TIMEOUT_CYC, 1000, cycles allowed per question before timeout (>=2).
- BEEP_CYC, 8, number of cycles `beep` stays high per beep event (>=1).
- WIN_SCORE, 5, score that ends the game immediately; matches the 5-LED score display.
- DEB_CYC, 16, debounce stability window in cycles; used only with DEBOUNCE_EN.

Ports:
- clk, input, 1, single system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, synchronous level; starts or restarts the game.
- btn_p1, input, 1, player 1 buzz button; raw and asynchronous.
- btn_p2, input, 1, player 2 buzz button; raw and asynchronous.
- ans_p1, input, 4, player 1 answer switches, BCD.
- ans_p2, input, 4, player 2 answer switches, BCD.
- bcd_ans, input, 4, expected answer for the current `bcd_state`.
- bcd_state, output, 4, current question index 0..9.
- score_trig_p1, output, 1, one-cycle pulse on a correct player 1 answer.
- score_trig_p2, output, 1, one-cycle pulse on a correct player 2 answer.
- beep, output, 1, held high for BEEP_CYC cycles per beep event.
- game_over, output, 1, high while in state OVER.
- winner, output, 2, valid while `game_over`=1: 00 tie, 01 P1, 10 P2.

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE, `bcd_state`=0.
  - Both scores=0; all outputs 0; timer=0; beep counter=0.
- Buttons: each passes through a 2-flop synchronizer, then a rising-edge detector. Result is `buzz_px`, one cycle per press. Button level is ignored; holding a button gives one buzz.
- States:
  - IDLE: `start`=1 -> ASK, with `bcd_state`=0 and scores=0.
  - ASK: load timer=TIMEOUT_CYC-1; go to WAIT next cycle. Buzzes arriving during ASK are discarded.
  - WAIT:
    - `buzz_p1` xor `buzz_p2`: latch that player's id and answer, then -> JUDGE.
    - Both in the same cycle: P1 wins when `bcd_state` is even, P2 when odd.
    - No buzz and timer=0: start beep, then -> NEXT.
    - Otherwise timer decrements.
  - JUDGE (1 cycle):
    - latched answer == `bcd_ans` (sampled this cycle): that player's score increments, saturating at WIN_SCORE, and `score_trig` is set for the next cycle.
    - Otherwise: start beep, no score change.
    - Always -> NEXT.
  - NEXT (1 cycle): `score_trig_px` is high during exactly this cycle.
    - Either score == WIN_SCORE, or `bcd_state`==9: -> OVER.
    - Else `bcd_state`+1 -> ASK.
  - OVER: `game_over`=1; `winner` from the score compare, held stable. `start`=1 -> ASK with `bcd_state`=0 and scores=0.
- Latency:
  - Button edge to `buzz_px`: 3 cycles.
  - `buzz_px` to JUDGE: 1 cycle.
  - `score_trig` rises 2 cycles after `buzz_px`.
- Beep: each start event loads the counter with BEEP_CYC; `beep` = (counter!=0). A new event while `beep` is still high reloads the counter (extends, not stacked).
- `bcd_state` never exceeds 9; there is no wrap past 9, the game ends instead.
- `start` outside IDLE and OVER is ignored.
- Reset asserted mid-game returns to IDLE immediately. Any in-flight score trigger or beep is cut.

Optional Feature:
- DEBOUNCE_EN defined:
  - A debounce stage sits between the synchronizer and the edge detector.
  - The filtered level changes only after the raw level has been stable for DEB_CYC consecutive cycles.
  - Button-to-buzz latency becomes 3+DEB_CYC cycles.
- DEBOUNCE_EN undefined: synchronizer + edge detect only; DEB_CYC is unused.

Decomposition:
- Shared package holds:
  - State enum: IDLE, ASK, WAIT, JUDGE, NEXT, OVER.
  - Constants LAST_Q=9 and WINNER_TIE/P1/P2 codes.
  - 3-bit score typedef.
- Sub-module btn_edge, instantiated twice: synchronizer, debounce under DEBOUNCE_EN, rising-edge pulse output.
- Beep counter and timer stay inline in answer_judge.

Test Plan:
1. Reset then `start`; in question 0 with `bcd_ans`=1, P1 presses with `ans_p1`=1 -> `score_trig_p1` pulses 1 cycle, `bcd_state` becomes 1, `beep`=0.
2. P2 answers 7 while `bcd_ans`=2 -> no trigger, `beep` high 8 cycles, `bcd_state` advances.
3. No press for 1000 cycles -> timeout beep, `bcd_state` advances, no trigger on either player.
4. Both buttons rise in the same cycle: at `bcd_state`=2, P1 is judged; at `bcd_state`=3, P2 is judged.
5. P1 correct 5 times in a row -> `game_over`=1 after the 5th NEXT, `winner`=01, `bcd_state`=4; later `start` -> `bcd_state`=0 and scores cleared.
6. rst_n pulled low in the JUDGE cycle -> all outputs 0 immediately, no `score_trig`. With DEBOUNCE_EN, a 5-cycle glitch produces no buzz.

Source files
------------

// File: rtl/answer_judge_pkg.sv
// answer_judge_pkg: shared types and constants for the answer judge.
package answer_judge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASK,
        WAIT,
        JUDGE,
        NEXT,
        OVER
    } state_t;

    typedef logic [2:0] score_t;

    localparam logic [3:0] LAST_Q     = 4'd9;
    localparam logic [1:0] WINNER_TIE = 2'b00;
    localparam logic [1:0] WINNER_P1  = 2'b01;
    localparam logic [1:0] WINNER_P2  = 2'b10;

endpackage

// File: rtl/answer_judge_if.sv
// answer_judge_if: player inputs, question answer and score/beep outputs.
interface answer_judge_if;
    logic       start;
    logic       btn_p1;
    logic       btn_p2;
    logic [3:0] ans_p1;
    logic [3:0] ans_p2;
    logic [3:0] bcd_ans;
    logic [3:0] bcd_state;
    logic       score_trig_p1;
    logic       score_trig_p2;
    logic       beep;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, btn_p1, btn_p2, ans_p1, ans_p2, bcd_ans,
        input  bcd_state, score_trig_p1, score_trig_p2, beep, game_over, winner
    );

    modport slave (
        input  start, btn_p1, btn_p2, ans_p1, ans_p2, bcd_ans,
        output bcd_state, score_trig_p1, score_trig_p2, beep, game_over, winner
    );
endinterface

// File: rtl/answer_judge_btn_edge.sv
// btn_edge: 2-flop synchronizer, optional debounce (DEBOUNCE_EN), registered
// rising-edge pulse. One pulse per press regardless of hold time.
module btn_edge #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic buzz
);
    logic [1:0] sync_q, sync_d;
    logic       lvl;
    logic       lvl_prev_q, lvl_prev_d;
    logic       buzz_q, buzz_d;

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYC + 1);
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Filtered level follows the synchronized level only after DEB_CYC steady cycles.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) filt_d = sync_q[1];
            else                            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    // An illegal window length shows up as a named marker block in the hierarchy.
    if (DEB_CYC < 1) begin : g_deb_cyc_invalid
    end

    assign lvl = sync_q[1];
`endif

    // Shift the raw button in and detect a low-to-high change of the clean level.
    always_comb begin
        sync_d     = {sync_q[0], btn};
        lvl_prev_d = lvl;
        buzz_d     = lvl & ~lvl_prev_q;
    end

    // Synchronizer, edge history and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            buzz_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            lvl_prev_q <= lvl_prev_d;
            buzz_q     <= buzz_d;
        end
    end

    assign buzz = buzz_q;
endmodule

// File: rtl/answer_judge.sv
// answer_judge: steps questions 0..9, judges buzzed answers, emits score
// triggers, beeps and game-over/winner. DEBOUNCE_EN adds button debounce.
module answer_judge
    import answer_judge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int BEEP_CYC    = 8,
    parameter int WIN_SCORE   = 5,
    parameter int DEB_CYC     = 16
) (
    input logic           clk,
    input logic           rst_n,
    answer_judge_if.slave bus
);
    localparam int     TW  = $clog2(TIMEOUT_CYC);
    localparam int     BW  = $clog2(BEEP_CYC + 1);
    localparam score_t WIN = score_t'(WIN_SCORE);

    state_t        state_q, state_d;
    logic [3:0]    bcd_q, bcd_d;
    score_t        sc1_q, sc1_d, sc2_q, sc2_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] beep_q, beep_d;
    logic          trig1_q, trig1_d, trig2_q, trig2_d;
    logic          who_q, who_d;      // 1: player 2 owns the latched answer
    logic [3:0]    ans_q, ans_d;
    logic          beep_evt;
    logic          buzz1, buzz2;
    logic          game_end;

    btn_edge #(.DEB_CYC(DEB_CYC)) u_btn_p1 (.clk(clk), .rst_n(rst_n), .btn(bus.btn_p1), .buzz(buzz1));
    btn_edge #(.DEB_CYC(DEB_CYC)) u_btn_p2 (.clk(clk), .rst_n(rst_n), .btn(bus.btn_p2), .buzz(buzz2));

    assign game_end = (sc1_q == WIN) || (sc2_q == WIN) || (bcd_q == LAST_Q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            sc1_q   <= '0;
            sc2_q   <= '0;
            timer_q <= '0;
            beep_q  <= '0;
            trig1_q <= 1'b0;
            trig2_q <= 1'b0;
            who_q   <= 1'b0;
            ans_q   <= '0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            sc1_q   <= sc1_d;
            sc2_q   <= sc2_d;
            timer_q <= timer_d;
            beep_q  <= beep_d;
            trig1_q <= trig1_d;
            trig2_q <= trig2_d;
            who_q   <= who_d;
            ans_q   <= ans_d;
        end
    end

    // Next-state logic of the question sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = ASK;
            ASK:     state_d = WAIT;
            WAIT:    if (buzz1 | buzz2)       state_d = JUDGE;
                     else if (timer_q == '0)  state_d = NEXT;
            JUDGE:   state_d = NEXT;
            NEXT:    state_d = game_end ? OVER : ASK;
            OVER:    if (bus.start) state_d = ASK;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: question index, scores, timer, buzz latch, triggers, beep.
    always_comb begin
        bcd_d    = bcd_q;
        sc1_d    = sc1_q;
        sc2_d    = sc2_q;
        timer_d  = timer_q;
        beep_d   = (beep_q != '0) ? beep_q - 1'b1 : beep_q;
        trig1_d  = 1'b0;
        trig2_d  = 1'b0;
        who_d    = who_q;
        ans_d    = ans_q;
        beep_evt = 1'b0;
        unique case (state_q)
            IDLE, OVER: if (bus.start) begin
                bcd_d = '0;
                sc1_d = '0;
                sc2_d = '0;
            end
            ASK: timer_d = TW'(TIMEOUT_CYC - 1);
            WAIT: begin
                if (buzz1 | buzz2) begin
                    // Simultaneous buzz: even question favours P1, odd favours P2.
                    who_d = buzz2 & (~buzz1 | bcd_q[0]);
                    ans_d = who_d ? bus.ans_p2 : bus.ans_p1;
                end else if (timer_q == '0) begin
                    beep_evt = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            JUDGE: begin
                if (ans_q == bus.bcd_ans) begin
                    if (who_q) begin
                        trig2_d = 1'b1;
                        if (sc2_q != WIN) sc2_d = sc2_q + 1'b1;
                    end else begin
                        trig1_d = 1'b1;
                        if (sc1_q != WIN) sc1_d = sc1_q + 1'b1;
                    end
                end else begin
                    beep_evt = 1'b1;
                end
            end
            NEXT: if (!game_end) bcd_d = bcd_q + 1'b1;
            default: ;
        endcase
        // A new event restarts the beep window rather than stacking.
        if (beep_evt) beep_d = BW'(BEEP_CYC);
    end

    // Output decode; winner only meaningful while the game is over.
    always_comb begin
        bus.bcd_state     = bcd_q;
        bus.score_trig_p1 = trig1_q;
        bus.score_trig_p2 = trig2_q;
        bus.beep          = (beep_q != '0);
        bus.game_over     = (state_q == OVER);
        bus.winner        = WINNER_TIE;
        if (state_q == OVER) begin
            if (sc1_q > sc2_q)      bus.winner = WINNER_P1;
            else if (sc2_q > sc1_q) bus.winner = WINNER_P2;
        end
    end
endmodule

// File: tb/tb_answer_judge.sv
// tb_answer_judge: directed and randomized games checked against a
// question-level reference model of the quiz rules.
module tb_answer_judge;
    localparam int TO  = 1000;
    localparam int BC  = 8;
    localparam int WIN = 5;
    localparam int DEB = 16;
`ifdef DEBOUNCE_EN
    localparam int BUZZ_LAT = 3 + DEB;
`else
    localparam int BUZZ_LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    answer_judge_if bus ();

    answer_judge #(.TIMEOUT_CYC(TO), .BEEP_CYC(BC), .WIN_SCORE(WIN), .DEB_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Answer ROM: expected answer of the displayed question.
    logic [3:0] key [10];
    assign bus.bcd_ans = (int'(bus.bcd_state) <= 9) ? key[int'(bus.bcd_state)] : 4'hf;

    int checks = 0, errors = 0;
    int cyc = 0, n_t1 = 0, n_t2 = 0, n_beep = 0, n_bev = 0;
    int t1_cyc = -1, t2_cyc = -1, bev_cyc = -1;
    logic beep_prev = 1'b0;
    int qstart = 0;
    int m_q = 0, m_s1 = 0, m_s2 = 0;
    bit m_over = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; sample on the falling edge and tally output activity.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.score_trig_p1) begin n_t1++; t1_cyc = cyc; end
        if (bus.score_trig_p2) begin n_t2++; t2_cyc = cyc; end
        if (bus.beep) n_beep++;
        if (bus.beep && !beep_prev) begin n_bev++; bev_cyc = cyc; end
        beep_prev = bus.beep;
    endtask

    task automatic wait_beep_low();
        for (int i = 0; i < BC + 4 && bus.beep; i++) tick();
    endtask

    function automatic logic [1:0] exp_win(input int s1, input int s2);
        if (s1 > s2) return 2'b01;
        if (s2 > s1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] pick(input logic [3:0] k);
        if ($urandom_range(0, 1) == 1) return k;
        return 4'((int'(k) + 1 + int'($urandom_range(0, 8))) % 10);
    endfunction

    task automatic start_game();
        wait_beep_low();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        qstart = cyc;
        m_q = 0; m_s1 = 0; m_s2 = 0; m_over = 1'b0;
        check("start_bcd", 32'(bus.bcd_state), 0);
        check("start_game_over", 32'(bus.game_over), 0);
    endtask

    // act: 0 none (timeout), 1 P1, 2 P2, 3 both in the same cycle.
    task automatic play_q(input int act, input logic [3:0] a1, input logic [3:0] a2, input bit mid_start);
        int ref_c, lat, judged, b1, b2, bb, be;
        bit ok, et1, et2, eb;
        wait_beep_low();
        bus.ans_p1 = a1;
        bus.ans_p2 = a2;
        if (mid_start) begin bus.start = 1'b1; tick(); bus.start = 1'b0; end
        repeat ($urandom_range(0, 12)) tick();
        b1 = n_t1; b2 = n_t2; bb = n_beep; be = n_bev;
        if (act == 0) begin
            ref_c = qstart; lat = TO + 2;
        end else begin
            ref_c = cyc; lat = BUZZ_LAT + 3;
            bus.btn_p1 = (act != 2);
            bus.btn_p2 = (act != 1);
        end
        while (int'(bus.bcd_state) == m_q && !bus.game_over && (cyc - ref_c) < lat + 20) tick();
        check("q_end_latency", 32'(cyc - ref_c), 32'(lat));
        qstart = cyc;
        bus.btn_p1 = 1'b0;
        bus.btn_p2 = 1'b0;

        judged = (act == 3) ? ((m_q % 2 == 0) ? 1 : 2) : act;
        ok  = (judged == 1 && a1 == key[m_q]) || (judged == 2 && a2 == key[m_q]);
        et1 = ok && judged == 1;
        et2 = ok && judged == 2;
        eb  = !ok;
        if (et1 && m_s1 < WIN) m_s1++;
        if (et2 && m_s2 < WIN) m_s2++;
        m_over = (m_s1 == WIN) || (m_s2 == WIN) || (m_q == 9);
        if (!m_over) m_q++;

        check("bcd_state", 32'(bus.bcd_state), 32'(m_q));
        check("game_over", 32'(bus.game_over), 32'(m_over));
        check("winner", 32'(bus.winner), m_over ? 32'(exp_win(m_s1, m_s2)) : 32'd0);
        if (et1) check("trig_p1_time", 32'(t1_cyc), 32'(ref_c + BUZZ_LAT + 2));
        if (et2) check("trig_p2_time", 32'(t2_cyc), 32'(ref_c + BUZZ_LAT + 2));
        if (eb)  check("beep_start", 32'(bev_cyc), 32'(ref_c + lat - 1));
        wait_beep_low();
        check("trig_p1_count", 32'(n_t1 - b1), 32'(et1));
        check("trig_p2_count", 32'(n_t2 - b2), 32'(et2));
        check("beep_cycles", 32'(n_beep - bb), eb ? 32'(BC) : 32'd0);
        check("beep_events", 32'(n_bev - be), 32'(eb));
        repeat (BUZZ_LAT) tick();
    endtask

    task automatic random_game();
        int r, act;
        start_game();
        for (int q = 0; q < 10 && !m_over; q++) begin
            r = int'($urandom_range(0, 15));
            act = (r == 0) ? 0 : (r <= 5) ? 1 : (r <= 10) ? 2 : 3;
            play_q(act, pick(key[m_q]), pick(key[m_q]), $urandom_range(0, 3) == 0);
        end
        check("random_game_ended", 32'(bus.game_over), 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1;
        bus.start = 1'b0; bus.btn_p1 = 1'b0; bus.btn_p2 = 1'b0;
        bus.ans_p1 = '0; bus.ans_p2 = '0;
        for (int i = 0; i < 10; i++) key[i] = 4'((i + 1) % 10);

        // Reset state.
        repeat (2) tick();
        check("rst_bcd", 32'(bus.bcd_state), 0);
        check("rst_trig_p1", 32'(bus.score_trig_p1), 0);
        check("rst_trig_p2", 32'(bus.score_trig_p2), 0);
        check("rst_beep", 32'(bus.beep), 0);
        check("rst_game_over", 32'(bus.game_over), 0);
        check("rst_winner", 32'(bus.winner), 0);
        rst_n = 1'b1;
        repeat (BUZZ_LAT) tick();

        // Directed game: correct P1, wrong P2, both (even/odd), timeout.
        start_game();
`ifdef DEBOUNCE_EN
        b1 = n_t1;
        bus.ans_p1 = key[0];
        bus.btn_p1 = 1'b1;
        repeat (5) tick();
        bus.btn_p1 = 1'b0;
        repeat (DEB + 10) tick();
        check("glitch_no_buzz_bcd", 32'(bus.bcd_state), 0);
        check("glitch_no_trig", 32'(n_t1 - b1), 0);
`endif
        play_q(1, 4'd1, 4'd0, 1'b0);
        play_q(2, 4'd0, 4'd7, 1'b0);
        play_q(3, key[2], 4'd9, 1'b0);
        play_q(3, key[3], key[3], 1'b0);
        play_q(0, 4'd0, 4'd0, 1'b0);
        for (int q = 0; q < 10 && !m_over; q++) play_q(1 + (q % 2), key[m_q], 4'd0, 1'b0);

        // P1 wins with five straight correct answers.
        start_game();
        for (int q = 0; q < 5; q++) play_q(1, key[m_q], 4'd0, 1'b0);
        check("win_bcd", 32'(bus.bcd_state), 4);
        check("win_winner", 32'(bus.winner), 1);
        repeat (4) tick();
        check("win_hold_game_over", 32'(bus.game_over), 1);
        check("win_hold_winner", 32'(bus.winner), 1);

        // Reset in the JUDGE cycle cuts the pending trigger.
        start_game();
        bus.ans_p1 = key[0];
        bus.btn_p1 = 1'b1;
        repeat (BUZZ_LAT + 1) tick();
        b1 = n_t1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_bcd", 32'(bus.bcd_state), 0);
        check("mid_rst_trig_p1", 32'(bus.score_trig_p1), 0);
        check("mid_rst_beep", 32'(bus.beep), 0);
        check("mid_rst_game_over", 32'(bus.game_over), 0);
        bus.btn_p1 = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (BUZZ_LAT + 2) tick();
        check("mid_rst_no_trig", 32'(n_t1 - b1), 0);
        check("mid_rst_idle_bcd", 32'(bus.bcd_state), 0);

        // Randomized games with random answer keys.
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 10; i++) key[i] = 4'($urandom_range(0, 9));
            random_game();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
